// File: rtl/wb_arb_mux.sv
// Wishbone B3 N-master to 1-slave arbiter/multiplexer with a registered one-hot grant,
// round-robin or fixed-priority arbitration, a stalled-slave watchdog and a bus-hold handshake.
module wb_arb_mux #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int TIMEOUT    = 256,
    localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [MASTERS-1:0]            m_we_i,
    input  logic [MASTERS*3-1:0]          m_cti_i,
    input  logic [MASTERS*2-1:0]          m_bte_i,
    input  logic [MASTERS-1:0]            m_cyc_i,
    input  logic [MASTERS-1:0]            m_stb_i,
    output logic [MASTERS*DATA_WIDTH-1:0] m_dat_o,
    output logic [MASTERS-1:0]            m_ack_o,
    output logic [MASTERS-1:0]            m_err_o,
    output logic [MASTERS-1:0]            m_rty_o,
    output logic [ADDR_WIDTH-1:0]         s_adr_o,
    output logic [DATA_WIDTH-1:0]         s_dat_o,
    output logic [SEL_WIDTH-1:0]          s_sel_o,
    output logic                          s_we_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    input  logic [DATA_WIDTH-1:0]         s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    input  logic                          bus_hold,
    output logic                          bus_hold_ack,
    output logic [MASTERS-1:0]            grant_o,
    output logic [1:0]                    fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int PTR_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LAST_I);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(MASTERS - 1);

    state_t             state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [MASTERS-1:0] winner;
    logic [PTR_W-1:0]   winner_idx;
    logic               found;
    int                 idx;
    logic               gnt_cyc;
    logic               term;

    assign gnt_cyc      = |(grant_q & m_cyc_i);
    assign term         = s_ack_i | s_err_i | s_rty_i;
    assign grant_o      = grant_q;
    assign bus_hold_ack = (state_q == HOLD);
    assign fsm_state    = state_q;
    assign m_dat_o      = {MASTERS{s_dat_i}};

    // Round-robin starts the search one past the last winner; priority always from index 0.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < MASTERS; i++) begin
                if (!found && m_cyc_i[i]) begin
                    found      = 1'b1;
                    winner[i]  = 1'b1;
                    winner_idx = PTR_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= MASTERS; k++) begin
                idx = (int'(ptr_q) + k) % MASTERS;
                if (!found && m_cyc_i[idx]) begin
                    found       = 1'b1;
                    winner[idx] = 1'b1;
                    winner_idx  = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (state_q == BUSY) begin
            for (int i = 0; i < MASTERS; i++) begin
                if (grant_q[i]) begin
                    s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                    s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                    s_sel_o = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                    s_we_o  = m_we_i[i];
                    s_cti_o = m_cti_i[i*3 +: 3];
                    s_bte_o = m_bte_i[i*2 +: 2];
                    s_cyc_o = m_cyc_i[i];
                    s_stb_o = m_cyc_i[i] & m_stb_i[i];
                end
            end
        end
    end

    // The watchdog abort error goes only to the master that owned the stalled cycle.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state_q == BUSY) begin
            m_ack_o = grant_q & {MASTERS{s_ack_i}};
            m_err_o = grant_q & {MASTERS{s_err_i}};
            m_rty_o = grant_q & {MASTERS{s_rty_i}};
        end else if (state_q == ABORT) begin
            m_err_o = grant_q;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (bus_hold) begin
                    state_d = HOLD;
                end else if (|m_cyc_i) begin
                    state_d = BUSY;
                    grant_d = winner;
                    ptr_d   = winner_idx;
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    wdog_d  = '0;
                end else if ((TIMEOUT > 0) && s_stb_o && !term) begin
                    if (wdog_q == WD_LAST) begin
                        state_d = ABORT;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            ABORT: begin
                wdog_d = '0;
                if (gnt_cyc) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            HOLD: begin
                if (!bus_hold) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_INIT;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule
